fmul_share_arb: RTL and testbench
=================================

// Module: fmul_share_arb
// PURPOSE
//  Two-port round-robin arbiter that shares one fixed-latency FP multiplier.
//  The two requesters are the fdiv sequencer and the standalone fmul issue port.
//  Each port uses a valid/ready request channel and a valid/ready response channel.
//  A tag pipeline matched to the multiplier latency routes each product to a per-port response FIFO.
//  Results are returned in order within each port.
// PARAMETERS
//  MUL_LATENCY  1  cycles from operands on mul_x1/mul_x2 (sampled at clk edge) to mul_y valid; 1..4
//  RESP_DEPTH   2  entries per response FIFO; must be >= MUL_LATENCY+1 for full per-port rate
// PORTS
//  clk         in   1   clock; all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid_a in   1   port A operands valid
//  req_ready_a out  1   port A request accepted this cycle (grant)
//  req_x1_a    in   32  port A operand 1
//  req_x2_a    in   32  port A operand 2
//  rsp_valid_a out  1   port A result available
//  rsp_ready_a in   1   port A consumer takes result
//  rsp_y_a     out  32  port A result (FIFO head)
//  req_*_b / rsp_*_b    same set of ports as A, for port B
//  mul_x1      out  32  operand 1 to shared multiplier
//  mul_x2      out  32  operand 2 to shared multiplier
//  mul_y       in   32  multiplier product, valid MUL_LATENCY cycles after issue
// BEHAVIOUR
//  - One clock, clk. Reset rst is asynchronous and active-high.
//  - Reset clears all state:
//    - rsp_valid_a/b=0; FIFOs empty; tag pipeline all invalid; rr pointer=B (A wins first).
//    - req_ready_a/b=0 while rst=1.
//  - Credit per port p: cnt_p = in-flight ops of p + FIFO occupancy of p.
//    - elig_p = req_valid_p && (cnt_p - pop_p) < RESP_DEPTH, where pop_p = rsp_valid_p && rsp_ready_p.
//    - A pop in the same cycle frees a credit immediately.
//  - Grant (combinational):
//    - Only one eligible port: that port is granted.
//    - Both eligible: the port != last granted is granted.
//    - Pointer updates only on a grant.
//    - req_ready_p = grant_p; a transfer is req_valid_p && req_ready_p.
//  - Operand mux: mul_x1/mul_x2 = granted port's operands.
//    - No grant: both driven 32'h0 (exp 0 -> zero product).
//  - Tag pipeline: MUL_LATENCY-deep shift of {valid, port}.
//    - Stage 0 is loaded with the grant at the clock edge that samples the operands.
//    - When the last stage is valid, mul_y is written into that port's FIFO at the next edge.
//    - Result visible on rsp_y_p / rsp_valid_p MUL_LATENCY+1 cycles after the accept cycle.
//  - FIFO: circular, RESP_DEPTH entries.
//    - Write and pop in the same cycle are legal; occupancy unchanged.
//    - Overflow is impossible by the credit rule (assert in sim).
//    - rsp_y_p is don't-care when rsp_valid_p=0.
//  - Reset mid-operation: in-flight products are dropped. No rsp_valid may appear for ops accepted before reset.
//  - Ports are fully independent: backpressure on one never stalls the other.
// TESTING (bench multiplier model: mul_y = MUL_LATENCY-cycle registered x1^x2; defaults)
//  1. rst=1 with req_valid_a/b=1 -> req_ready_a/b=0, rsp_valid_a/b=0, mul_x1=mul_x2=0.
//  2. A alone, x1=32'h3F800000, x2=32'h00000001, accepted cycle t
//     -> rsp_valid_a=1 at t+2, rsp_y_a=32'h3F800001.
//  3. A and B valid every cycle, rsp_ready=1
//     -> grants A,B,A,B...; one issue per cycle; each port gets results in issue order.
//  4. A valid every cycle, rsp_ready_a=0
//     -> exactly 2 A accepts, then req_ready_a=0.
//     -> B still granted every cycle.
//     -> raise rsp_ready_a: both A results drain in order, then A resumes.
//  5. A at cnt=2 with rsp_ready_a=1 and req_valid_a=1 in the same cycle
//     -> pop and accept both happen; occupancy stays 2.
//  6. Assert rst with 1 A op in flight and 1 buffered
//     -> rsp_valid_a=0 immediately; after release, no A response appears within 5 cycles.

Source files
------------

// File: rtl/fmul_share_arb.sv
// ============================================================================
// Module      : fmul_share_arb
// Description : Round-robin sharing of one fixed-latency FP multiplier between
//               two valid/ready requesters, with per-port in-order result FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_share_arb #(
    parameter int MUL_LATENCY = 1,
    parameter int RESP_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_a,
    output logic        req_ready_a,
    input  logic [31:0] req_x1_a,
    input  logic [31:0] req_x2_a,
    output logic        rsp_valid_a,
    input  logic        rsp_ready_a,
    output logic [31:0] rsp_y_a,
    input  logic        req_valid_b,
    output logic        req_ready_b,
    input  logic [31:0] req_x1_b,
    input  logic [31:0] req_x2_b,
    output logic        rsp_valid_b,
    input  logic        rsp_ready_b,
    output logic [31:0] rsp_y_b,
    output logic [31:0] mul_x1,
    output logic [31:0] mul_x2,
    input  logic [31:0] mul_y
);

    localparam int c_cnt_w = $clog2(RESP_DEPTH + 1);
    localparam int c_ptr_w = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e                  last_q;
    logic [MUL_LATENCY-1:0] tag_v_q;
    logic [MUL_LATENCY-1:0] tag_p_q;

    logic [1:0]  w_req_valid;
    logic [1:0]  w_rsp_ready;
    logic [1:0]  w_rsp_valid;
    logic [1:0]  w_pop;
    logic [1:0]  w_elig;
    logic [1:0]  w_gnt;
    logic [1:0]  w_wr;
    logic [31:0] w_rsp_y [2];

    assign w_req_valid = {req_valid_b, req_valid_a};
    assign w_rsp_ready = {rsp_ready_b, rsp_ready_a};

    assign req_ready_a = w_gnt[0];
    assign req_ready_b = w_gnt[1];
    assign rsp_valid_a = w_rsp_valid[0];
    assign rsp_valid_b = w_rsp_valid[1];
    assign rsp_y_a     = w_rsp_y[0];
    assign rsp_y_b     = w_rsp_y[1];

    // Ties go to the port that was not granted last.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (w_elig[0] && (!w_elig[1] || last_q == PORT_B)) begin
                w_gnt[0] = 1'b1;
            end else if (w_elig[1]) begin
                w_gnt[1] = 1'b1;
            end
        end
    end

    always_comb begin
        mul_x1 = 32'h0;
        mul_x2 = 32'h0;
        if (w_gnt[0]) begin
            mul_x1 = req_x1_a;
            mul_x2 = req_x2_a;
        end else if (w_gnt[1]) begin
            mul_x1 = req_x1_b;
            mul_x2 = req_x2_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_B;
        end else if (|w_gnt) begin
            last_q <= w_gnt[1] ? PORT_B : PORT_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_q <= '0;
            tag_p_q <= '0;
        end else begin
            tag_v_q[0] <= |w_gnt;
            tag_p_q[0] <= w_gnt[1];
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_p_q[i] <= tag_p_q[i-1];
            end
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [c_cnt_w-1:0] cnt_q;
            logic [c_cnt_w-1:0] cnt_d;
            logic [c_cnt_w-1:0] occ_q;
            logic [c_cnt_w-1:0] occ_d;
            logic [c_ptr_w-1:0] wptr_q;
            logic [c_ptr_w-1:0] rptr_q;
            logic [31:0]        mem_q [RESP_DEPTH];

            assign w_rsp_valid[p] = (occ_q != '0);
            assign w_pop[p]       = w_rsp_valid[p] && w_rsp_ready[p];
            // A same-cycle pop releases its credit to this cycle's request.
            assign w_elig[p]      = w_req_valid[p] && ((int'(cnt_q) < RESP_DEPTH) || w_pop[p]);
            assign w_wr[p]        = tag_v_q[MUL_LATENCY-1] && (tag_p_q[MUL_LATENCY-1] == 1'(p));
            assign w_rsp_y[p]     = mem_q[rptr_q];

            always_comb begin
                cnt_d = cnt_q + c_cnt_w'(w_gnt[p]) - c_cnt_w'(w_pop[p]);
                occ_d = occ_q + c_cnt_w'(w_wr[p])  - c_cnt_w'(w_pop[p]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q  <= '0;
                    occ_q  <= '0;
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    occ_q <= occ_d;
                    if (w_wr[p]) begin
                        wptr_q <= (int'(wptr_q) == RESP_DEPTH - 1) ? '0 : wptr_q + c_ptr_w'(1);
                    end
                    if (w_pop[p]) begin
                        rptr_q <= (int'(rptr_q) == RESP_DEPTH - 1) ? '0 : rptr_q + c_ptr_w'(1);
                    end
                    if (w_wr[p] && !w_pop[p]) begin
                        assert (int'(occ_q) < RESP_DEPTH);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_wr[p]) begin
                    mem_q[wptr_q] <= mul_y;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fmul_share_arb.sv
// ============================================================================
// Module      : tb_fmul_share_arb
// Description : Directed vector bench for fmul_share_arb (x1^x2 multiplier model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmul_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_ready_a, req_ready_b;
    logic [31:0] req_x1_a = '0, req_x2_a = '0, req_x1_b = '0, req_x2_b = '0;
    logic        rsp_valid_a, rsp_valid_b;
    logic        rsp_ready_a = 1'b0, rsp_ready_b = 1'b0;
    logic [31:0] rsp_y_a, rsp_y_b;
    logic [31:0] mul_x1, mul_x2;
    logic [31:0] mul_y = '0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        va, vb, ra, rb;
        logic [31:0] x1a, x2a, x1b, x2b;
        logic        e_rdya, e_rdyb;
        logic [31:0] e_m1, e_m2;
        logic        e_va, e_vb;
        logic [31:0] e_ya, e_yb;
    } vec_t;

    vec_t tbl_main [12];
    vec_t tbl_t5   [13];
    logic accb [10];

    fmul_share_arb #(.MUL_LATENCY(1), .RESP_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_a (req_valid_a),
        .req_ready_a (req_ready_a),
        .req_x1_a    (req_x1_a),
        .req_x2_a    (req_x2_a),
        .rsp_valid_a (rsp_valid_a),
        .rsp_ready_a (rsp_ready_a),
        .rsp_y_a     (rsp_y_a),
        .req_valid_b (req_valid_b),
        .req_ready_b (req_ready_b),
        .req_x1_b    (req_x1_b),
        .req_x2_b    (req_x2_b),
        .rsp_valid_b (rsp_valid_b),
        .rsp_ready_b (rsp_ready_b),
        .rsp_y_b     (rsp_y_b),
        .mul_x1      (mul_x1),
        .mul_x2      (mul_x2),
        .mul_y       (mul_y)
    );

    always #5 clk = ~clk;

    // One-cycle multiplier stand-in.
    always_ff @(posedge clk) mul_y <= mul_x1 ^ mul_x2;

    function automatic vec_t mk(
        input logic va, vb, ra, rb,
        input logic [31:0] x1a, x2a, x1b, x2b,
        input logic e_rdya, e_rdyb,
        input logic [31:0] e_m1, e_m2,
        input logic e_va, e_vb,
        input logic [31:0] e_ya, e_yb);
        vec_t v;
        v.va = va; v.vb = vb; v.ra = ra; v.rb = rb;
        v.x1a = x1a; v.x2a = x2a; v.x1b = x1b; v.x2b = x2b;
        v.e_rdya = e_rdya; v.e_rdyb = e_rdyb; v.e_m1 = e_m1; v.e_m2 = e_m2;
        v.e_va = e_va; v.e_vb = e_vb; v.e_ya = e_ya; v.e_yb = e_yb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input string tag, input int idx, input vec_t v);
        req_valid_a = v.va;  req_valid_b = v.vb;
        rsp_ready_a = v.ra;  rsp_ready_b = v.rb;
        req_x1_a = v.x1a; req_x2_a = v.x2a; req_x1_b = v.x1b; req_x2_b = v.x2b;
        #3;
        chk($sformatf("%s[%0d] req_ready_a", tag, idx), 32'(req_ready_a), 32'(v.e_rdya));
        chk($sformatf("%s[%0d] req_ready_b", tag, idx), 32'(req_ready_b), 32'(v.e_rdyb));
        chk($sformatf("%s[%0d] mul_x1", tag, idx), mul_x1, v.e_m1);
        chk($sformatf("%s[%0d] mul_x2", tag, idx), mul_x2, v.e_m2);
        chk($sformatf("%s[%0d] rsp_valid_a", tag, idx), 32'(rsp_valid_a), 32'(v.e_va));
        chk($sformatf("%s[%0d] rsp_valid_b", tag, idx), 32'(rsp_valid_b), 32'(v.e_vb));
        if (v.e_va) chk($sformatf("%s[%0d] rsp_y_a", tag, idx), rsp_y_a, v.e_ya);
        if (v.e_vb) chk($sformatf("%s[%0d] rsp_y_b", tag, idx), rsp_y_b, v.e_yb);
        next_cycle();
    endtask

    initial begin
        // Single A op, then alternating A/B traffic with rsp_ready held high.
        tbl_main[0]  = mk(1,0,1,1, 32'h3F800000,32'h1, 0,0,       1,0, 32'h3F800000,32'h1,   0,0, 0,0);
        tbl_main[1]  = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  0,0, 0,0);
        tbl_main[2]  = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  1,0, 32'h3F800001,0);
        tbl_main[3]  = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  0,0, 0,0);
        tbl_main[4]  = mk(1,1,1,1, 32'hA0000010,1,32'hB0000010,32'h100, 0,1, 32'hB0000010,32'h100, 0,0, 0,0);
        tbl_main[5]  = mk(1,1,1,1, 32'hA0000010,1,32'hB0000020,32'h100, 1,0, 32'hA0000010,32'h1,   0,0, 0,0);
        tbl_main[6]  = mk(1,1,1,1, 32'hA0000020,1,32'hB0000020,32'h100, 0,1, 32'hB0000020,32'h100, 0,1, 0,32'hB0000110);
        tbl_main[7]  = mk(1,1,1,1, 32'hA0000020,1,32'hB0000030,32'h100, 1,0, 32'hA0000020,32'h1,   1,0, 32'hA0000011,0);
        tbl_main[8]  = mk(1,1,1,1, 32'hA0000030,1,32'hB0000030,32'h100, 0,1, 32'hB0000030,32'h100, 0,1, 0,32'hB0000120);
        tbl_main[9]  = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  1,0, 32'hA0000021,0);
        tbl_main[10] = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  0,1, 0,32'hB0000130);
        tbl_main[11] = mk(0,0,1,1, 0,0,0,0,                        0,0, 0,0,                  0,0, 0,0);

        // Drain of the backpressured A FIFO, A resumes, then pop+accept at full credit.
        tbl_t5[0]  = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                0,0, 0,0);
        tbl_t5[0].e_va = 1; tbl_t5[0].e_ya = 32'hC0000001;
        tbl_t5[1]  = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                1,0, 32'hC0000000,0);
        tbl_t5[2]  = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                0,0, 0,0);
        tbl_t5[3]  = mk(1,0,0,1, 32'hC0000002,1,0,0,      1,0, 32'hC0000002,32'h1, 0,0, 0,0);
        tbl_t5[4]  = mk(1,0,0,1, 32'hC0000003,1,0,0,      1,0, 32'hC0000003,32'h1, 0,0, 0,0);
        tbl_t5[5]  = mk(1,0,0,1, 32'hC0000004,1,0,0,      0,0, 0,0,                1,0, 32'hC0000003,0);
        tbl_t5[6]  = mk(1,0,0,1, 32'hC0000004,1,0,0,      0,0, 0,0,                1,0, 32'hC0000003,0);
        tbl_t5[7]  = mk(1,0,1,1, 32'hC0000004,1,0,0,      1,0, 32'hC0000004,32'h1, 1,0, 32'hC0000003,0);
        tbl_t5[8]  = mk(0,0,0,1, 0,0,0,0,                 0,0, 0,0,                1,0, 32'hC0000002,0);
        tbl_t5[9]  = mk(1,0,0,1, 32'hC0000005,1,0,0,      0,0, 0,0,                1,0, 32'hC0000002,0);
        tbl_t5[10] = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                1,0, 32'hC0000002,0);
        tbl_t5[11] = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                1,0, 32'hC0000005,0);
        tbl_t5[12] = mk(0,0,1,1, 0,0,0,0,                 0,0, 0,0,                0,0, 0,0);

        // Reset with both requesters asserting valid.
        req_valid_a = 1'b1; req_valid_b = 1'b1;
        req_x1_a = 32'h12345678; req_x2_a = 32'h1; req_x1_b = 32'h9ABCDEF0; req_x2_b = 32'h1;
        next_cycle();
        next_cycle();
        chk("rst req_ready_a", 32'(req_ready_a), 32'h0);
        chk("rst req_ready_b", 32'(req_ready_b), 32'h0);
        chk("rst rsp_valid_a", 32'(rsp_valid_a), 32'h0);
        chk("rst rsp_valid_b", 32'(rsp_valid_b), 32'h0);
        chk("rst mul_x1", mul_x1, 32'h0);
        chk("rst mul_x2", mul_x2, 32'h0);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) apply_row("main", i, tbl_main[i]);

        // A backpressured while B keeps streaming.
        begin
            int nacc;
            logic exp_a;
            nacc = 0;
            rsp_ready_a = 1'b0; rsp_ready_b = 1'b1;
            req_x2_a = 32'h1; req_x2_b = 32'h100;
            for (int i = 0; i < 10; i++) begin
                exp_a   = (i == 0) || (i == 2);
                accb[i] = (i < 8) && !exp_a;
                req_valid_a = (i < 8);
                req_valid_b = (i < 8);
                req_x1_a = 32'hC0000000 + 32'(nacc);
                req_x1_b = 32'hD0000000 + 32'(i);
                #3;
                chk($sformatf("bp[%0d] req_ready_a", i), 32'(req_ready_a), 32'(exp_a));
                chk($sformatf("bp[%0d] req_ready_b", i), 32'(req_ready_b), 32'(accb[i]));
                chk($sformatf("bp[%0d] mul_x1", i), mul_x1,
                    exp_a ? req_x1_a : (accb[i] ? req_x1_b : 32'h0));
                chk($sformatf("bp[%0d] rsp_valid_a", i), 32'(rsp_valid_a), 32'(i >= 2));
                if (i >= 2) begin
                    chk($sformatf("bp[%0d] rsp_y_a", i), rsp_y_a, 32'hC0000001);
                    chk($sformatf("bp[%0d] rsp_valid_b", i), 32'(rsp_valid_b), 32'(accb[i-2]));
                    if (accb[i-2])
                        chk($sformatf("bp[%0d] rsp_y_b", i), rsp_y_b, (32'hD0000000 + 32'(i - 2)) ^ 32'h100);
                end
                if (exp_a) nacc++;
                next_cycle();
            end
        end

        for (int i = 0; i < 13; i++) apply_row("t5", i, tbl_t5[i]);

        // Reset with one A op in flight and one buffered.
        rsp_ready_a = 1'b0; req_valid_b = 1'b0; req_x2_a = 32'h1;
        req_valid_a = 1'b1; req_x1_a = 32'hE0000000;
        #3 chk("rr e0 req_ready_a", 32'(req_ready_a), 32'h1);
        next_cycle();
        req_x1_a = 32'hE0000001;
        #3 chk("rr e1 req_ready_a", 32'(req_ready_a), 32'h1);
        next_cycle();
        req_valid_a = 1'b0;
        #1 chk("rr buffered rsp_valid_a", 32'(rsp_valid_a), 32'h1);
        rst = 1'b1;
        #1 chk("rr in-reset rsp_valid_a", 32'(rsp_valid_a), 32'h0);
        next_cycle();
        rst = 1'b0;
        rsp_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3 chk($sformatf("rr post[%0d] rsp_valid_a", i), 32'(rsp_valid_a), 32'h0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
